m_imem_loader: RTL and testbench

Program loader that writes instruction words into the processor's instruction memory before execution starts. It accepts a byte stream over a valid/ready handshake: a 16-bit word-count header followed by the payload. Payload bytes are assembled into 32-bit little-endian words and written through a single write port at consecutive word-aligned byte addresses starting at 0. Once the load completes without error, the block releases the processor core through `w_proc_run`.

---
 rtl/m_imem_loader.sv | 190 +++++++++++++++++++
 tb/tb_m_imem_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/m_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | m_imem_loader : byte-stream instruction-memory loader; releases the core    |
// |   after a clean load. Optional trailing checksum: IMEM_LOADER_CHECKSUM_EN.  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module m_imem_loader #(
  parameter int DEPTH = 256
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        w_start,
  input  logic        w_in_valid,
  input  logic [7:0]  w_in_data,
  output logic        w_in_ready,
  output logic        w_we,
  output logic [31:0] w_waddr,
  output logic [31:0] w_wdata,
  output logic        w_busy,
  output logic        w_done,
  output logic        w_err,
  output logic        w_proc_run
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [16:0] c_DEPTH = 17'(DEPTH);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t c_AFTER_PAYLOAD = S_CSUM;
  localparam logic   c_CSUM_EN       = 1'b1;
`else
  localparam state_t c_AFTER_PAYLOAD = S_DONE;
  localparam logic   c_CSUM_EN       = 1'b0;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_len;
  logic [15:0] r_idx;
  logic [1:0]  r_bcnt;
  logic [23:0] r_word;
  logic        r_we;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;
  logic        r_done;
  logic        r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  logic        w_acc;
  logic [15:0] w_len_full;
  logic        w_oversize;
  logic        w_len_zero;
  logic        w_last_byte;
  logic        w_last_word;
  logic        w_restart;

  assign w_acc       = w_in_valid && w_in_ready;
  assign w_len_full  = {w_in_data, r_len[7:0]};
  assign w_oversize  = ({1'b0, w_len_full} > c_DEPTH);
  assign w_len_zero  = (w_len_full == 16'd0);
  assign w_last_byte = (r_bcnt == 2'd3);
  assign w_last_word = (r_idx == (r_len - 16'd1));
  assign w_restart   = w_start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) w_state_nxt = S_LEN0;
      end
      S_LEN0: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (w_acc) w_state_nxt = S_LEN1;
      end
      S_LEN1: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (w_acc) begin
          if (w_oversize)      w_state_nxt = S_DONE;
          else if (w_len_zero) w_state_nxt = c_AFTER_PAYLOAD;
          else                 w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (w_acc && w_last_byte && w_last_word) w_state_nxt = c_AFTER_PAYLOAD;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (w_acc) w_state_nxt = S_DONE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
      r_len   <= 16'd0;
      r_idx   <= 16'd0;
      r_bcnt  <= 2'd0;
      r_word  <= 24'd0;
      r_we    <= 1'b0;
      r_waddr <= 32'd0;
      r_wdata <= 32'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum  <= 8'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_we    <= 1'b0;
      if (w_restart) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
        r_idx  <= 16'd0;
        r_bcnt <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_csum <= 8'd0;
`endif
      end
      if (w_acc) begin
        case (r_state)
          S_LEN0: r_len[7:0] <= w_in_data;
          S_LEN1: begin
            r_len <= w_len_full;
            if (w_oversize) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else if (w_len_zero && !c_CSUM_EN) begin
              r_done <= 1'b1;
            end
          end
          S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ w_in_data;
`endif
            r_bcnt <= r_bcnt + 2'd1;
            case (r_bcnt)
              2'd0: r_word[7:0]   <= w_in_data;
              2'd1: r_word[15:8]  <= w_in_data;
              2'd2: r_word[23:16] <= w_in_data;
              default: begin
                r_wdata <= {w_in_data, r_word};
                r_waddr <= {14'd0, r_idx, 2'b00};
                r_we    <= 1'b1;
                r_idx   <= r_idx + 16'd1;
                // done rises together with the final strobe when no checksum follows
                if (w_last_word && !c_CSUM_EN) r_done <= 1'b1;
              end
            endcase
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          S_CSUM: begin
            r_done <= 1'b1;
            r_err  <= (r_csum != w_in_data);
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign w_we       = r_we;
  assign w_waddr    = r_waddr;
  assign w_wdata    = r_wdata;
  assign w_done     = r_done;
  assign w_err      = r_err;
  assign w_proc_run = r_done && !r_err;

endmodule
`default_nettype wire

// File: tb/tb_m_imem_loader.sv
`default_nettype none
// Scoreboard bench for m_imem_loader: randomized loads, queue of expected writes
// drained by a negedge monitor.
module tb_m_imem_loader;

  logic        w_clk = 1'b0;
  logic        w_rst_n;
  logic        w_start;
  logic        w_in_valid;
  logic [7:0]  w_in_data;
  logic        w_in_ready;
  logic        w_we;
  logic [31:0] w_waddr;
  logic [31:0] w_wdata;
  logic        w_busy;
  logic        w_done;
  logic        w_err;
  logic        w_proc_run;

  m_imem_loader #(.DEPTH(256)) u_dut (
    .w_clk      (w_clk),
    .w_rst_n    (w_rst_n),
    .w_start    (w_start),
    .w_in_valid (w_in_valid),
    .w_in_data  (w_in_data),
    .w_in_ready (w_in_ready),
    .w_we       (w_we),
    .w_waddr    (w_waddr),
    .w_wdata    (w_wdata),
    .w_busy     (w_busy),
    .w_done     (w_done),
    .w_err      (w_err),
    .w_proc_run (w_proc_run)
  );

  always #5 w_clk = ~w_clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  r_alt = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation
  always @(negedge w_clk) begin
    wr_t e;
    if (w_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with none expected", w_waddr, w_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("waddr", w_waddr, e.a);
        chk("wdata", w_wdata, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps
  task automatic send_byte(input logic [7:0] b, input int mode);
    bit gap;
    if (mode == 1) begin
      gap = r_alt;
      r_alt = ~r_alt;
    end else if (mode == 2) begin
      gap = 1'($urandom_range(0, 1));
    end else begin
      gap = 1'b0;
    end
    if (gap) begin
      w_in_valid = 1'b0;
      tick();
    end
    w_in_valid = 1'b1;
    w_in_data  = b;
    chk("in_ready", w_in_ready, 1);
    tick();
    w_in_valid = 1'b0;
  endtask

  task automatic run_load(input logic [15:0] n, input logic [7:0] pl[$], input int mode,
                          input bit bad_csum, input bit poke_start, input bit use_model);
    bit         oversize;
    bit         exp_err;
    logic [7:0] csum;
    oversize = (n > 16'd256);
    csum = 8'h00;
    foreach (pl[i]) csum = csum ^ pl[i];
    if (use_model && !oversize)
      for (int i = 0; i < int'(n); i++)
        exp_q.push_back('{a: 32'(i * 4), d: {pl[4*i+3], pl[4*i+2], pl[4*i+1], pl[4*i]}});

    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    chk("busy_after_start", w_busy, 1);
    chk("done_cleared", w_done, 0);
    send_byte(n[7:0], mode);
    send_byte(n[15:8], mode);

    if (oversize) begin
      chk("ovs_done", w_done, 1);
      chk("ovs_err", w_err, 1);
      chk("ovs_run", w_proc_run, 0);
      w_in_valid = 1'b1;
      w_in_data  = 8'hA5;
      repeat (3) begin
        chk("ovs_ready", w_in_ready, 0);
        tick();
      end
      w_in_valid = 1'b0;
      chk("ovs_done_hold", w_done, 1);
      return;
    end

    foreach (pl[i]) begin
      if (poke_start && i == 1) w_start = 1'b1;
      send_byte(pl[i], mode);
      w_start = 1'b0;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? (csum ^ 8'($urandom_range(1, 255))) : csum, mode);
    exp_err = bad_csum;
`else
    exp_err = 1'b0;
    if (n != 16'd0) chk("final_we_same_edge", w_we, 1);
`endif
    chk("done", w_done, 1);
    chk("err", w_err, 32'(exp_err));
    chk("proc_run", w_proc_run, 32'(!exp_err));
    chk("busy_end", w_busy, 0);
    chk("ready_end", w_in_ready, 0);
    @(negedge w_clk);
    #1;
    chk("pending_writes", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, w_in_ready, 0);
    chk({tag, "_we"}, w_we, 0);
    chk({tag, "_waddr"}, w_waddr, 0);
    chk({tag, "_wdata"}, w_wdata, 0);
    chk({tag, "_busy"}, w_busy, 0);
    chk({tag, "_done"}, w_done, 0);
    chk({tag, "_err"}, w_err, 0);
    chk({tag, "_run"}, w_proc_run, 0);
  endtask

  initial begin
    logic [7:0]  norm[$];
    logic [7:0]  empty[$];
    logic [7:0]  rp[$];
    logic [15:0] rn;
    norm = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h40, 8'h00};
    w_rst_n = 1'b0;
    w_start = 1'b0;
    w_in_valid = 1'b0;
    w_in_data = 8'h00;
    repeat (3) tick();
    chk_reset_outputs("rst");
    w_rst_n = 1'b1;
    tick();

    // Directed normal load, fixed expectations
    exp_q.push_back('{a: 32'h0, d: 32'h00100013});
    exp_q.push_back('{a: 32'h4, d: 32'h00400093});
    run_load(16'd2, norm, 0, 1'b0, 1'b0, 1'b0);

    run_load(16'd0, empty, 0, 1'b0, 1'b0, 1'b1);
    run_load(16'h0101, empty, 0, 1'b0, 1'b0, 1'b1);

    exp_q.push_back('{a: 32'h0, d: 32'h00100013});
    exp_q.push_back('{a: 32'h4, d: 32'h00400093});
    r_alt = 1'b1;
    run_load(16'd2, norm, 1, 1'b0, 1'b0, 1'b0);

    // Reset partway through the first word, with start also asserted
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    w_rst_n = 1'b0;
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    chk_reset_outputs("midrst");
    w_rst_n = 1'b1;
    tick();
    tick();
    chk("midrst_idle_we", w_we, 0);
    exp_q.push_back('{a: 32'h0, d: 32'h00100013});
    exp_q.push_back('{a: 32'h4, d: 32'h00400093});
    run_load(16'd2, norm, 0, 1'b0, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_q.push_back('{a: 32'h0, d: 32'h00100013});
    exp_q.push_back('{a: 32'h4, d: 32'h00400093});
    run_load(16'd2, norm, 0, 1'b1, 1'b0, 1'b0);
`endif

    for (int it = 0; it < 14; it++) begin
      rp.delete();
      if ($urandom_range(0, 4) == 0) rn = 16'($urandom_range(257, 65535));
      else rn = 16'($urandom_range(0, 6));
      if (rn <= 16'd256)
        for (int k = 0; k < 4 * int'(rn); k++) rp.push_back(8'($urandom));
      run_load(rn, rp, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b1);
    end

    // Capacity boundary: DEPTH words accepted, DEPTH+1 rejected
    rp.delete();
    for (int k = 0; k < 1024; k++) rp.push_back(8'($urandom));
    run_load(16'd256, rp, 0, 1'b0, 1'b0, 1'b1);
    run_load(16'd257, empty, 2, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
